btn_press_classifier: RTL



---
 rtl/btn_press_classifier_pkg.sv | 17 +
 rtl/btn_press_classifier_if.sv | 26 ++
 rtl/btn_press_classifier.sv | 118 +++++++++++
 3 files changed

// File: rtl/btn_press_classifier_pkg.sv
// Shared types and constants for the button press classifier.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG_HELD
    } btn_state_t;

    localparam int unsigned CLKS_PER_MS_DEFAULT = 100_000;

    // Larger of two unsigned values; used to size the shared hold/repeat counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_press_classifier_if.sv
// Button level in, command events out. The classifier is the slave side.
interface btn_press_classifier_if;

    logic btn_db;
    logic short_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic held;

    modport master (
        output btn_db,
        input  short_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  held
    );

    modport slave (
        input  btn_db,
        output short_pulse,
        output long_pulse,
        output repeat_pulse,
        output held
    );

endinterface

// File: rtl/btn_press_classifier.sv
// Classifies debounced button presses into short / long / auto-repeat events.
// All outputs are registered; each pulse is exactly one cycle wide.
module btn_press_classifier
    import btn_pkg::*;
#(
    parameter int unsigned CLKS_PER_MS   = CLKS_PER_MS_DEFAULT,
    parameter int unsigned LONG_PRESS_MS = 1000,
    parameter int unsigned REPEAT_MS     = 200,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    btn_press_classifier_if.slave  bus
);

    localparam int unsigned LONG_CLKS = LONG_PRESS_MS * CLKS_PER_MS;
    localparam int unsigned REP_CLKS  = REPEAT_MS * CLKS_PER_MS;
    // Floor of 2 keeps the width legal even when the parameter check below fires.
    localparam int unsigned CntW      = $clog2(max_u(max_u(LONG_CLKS, REP_CLKS), 2));

    localparam logic [CntW-1:0] LongLast = CntW'(LONG_CLKS - 1);
    localparam logic [CntW-1:0] RepLast  = CntW'(REP_CLKS - 1);

    if (LONG_CLKS < 2 || REP_CLKS < 2) begin : g_param_check
        $error("btn_press_classifier: LONG_CLKS and REP_CLKS must both be >= 2");
    end

    btn_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            btn_prev_q, btn_prev_d;
    logic            short_pulse_q, short_pulse_d;
    logic            long_pulse_q, long_pulse_d;
    logic            repeat_pulse_q, repeat_pulse_d;
    logic            held_q, held_d;
    logic            rise;

    // History resets high so a button held through reset must be released before it counts.
    assign rise = bus.btn_db & ~btn_prev_q;

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        btn_prev_d     = bus.btn_db;
        short_pulse_d  = 1'b0;
        long_pulse_d   = 1'b0;
        repeat_pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end
            end
            PRESSED: begin
                // Release takes priority over reaching the long-press threshold.
                if (!bus.btn_db) begin
                    short_pulse_d = 1'b1;
                    state_d       = IDLE;
                    cnt_d         = '0;
                end else if (cnt_q == LongLast) begin
                    long_pulse_d = 1'b1;
                    state_d      = LONG_HELD;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LONG_HELD: begin
                if (!bus.btn_db) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (REPEAT_EN) begin
                    if (cnt_q == RepLast) begin
                        repeat_pulse_d = 1'b1;
                        cnt_d          = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d != IDLE);
    end

    // State, counter, edge history and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            btn_prev_q     <= 1'b1;
            short_pulse_q  <= 1'b0;
            long_pulse_q   <= 1'b0;
            repeat_pulse_q <= 1'b0;
            held_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            btn_prev_q     <= btn_prev_d;
            short_pulse_q  <= short_pulse_d;
            long_pulse_q   <= long_pulse_d;
            repeat_pulse_q <= repeat_pulse_d;
            held_q         <= held_d;
        end
    end

    assign bus.short_pulse  = short_pulse_q;
    assign bus.long_pulse   = long_pulse_q;
    assign bus.repeat_pulse = repeat_pulse_q;
    assign bus.held         = held_q;

endmodule
